// File: rtl/fw_boot_loader_if.sv
// ----------------------------------------------------------------------------
// fw_boot_loader_if
//   Groups the firmware byte stream (valid/ready) and the memory write port
//   driven by the boot loader.
//
//   slave  : the loader side. It consumes in_data/in_valid, returns in_ready
//            and drives the memory write port.
//   master : the host side. It drives the stream and observes the write port.
//
//   in_data  [REG_WIDTH]   stream byte
//   in_valid               in_data is valid
//   in_ready               loader accepts a byte this cycle
//   mem_we                 memory write strobe (one pulse per byte)
//   mem_addr [ADDR_WIDTH]  memory write address
//   mem_din  [REG_WIDTH]   memory write data
// ----------------------------------------------------------------------------
interface fw_boot_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
) ();
  logic [REG_WIDTH-1:0]  in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_din;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/fw_boot_loader.sv
// ----------------------------------------------------------------------------
// fw_boot_loader
//   Holds the 6502 in reset while a firmware image streams in. Each byte is
//   written to memory starting at BASE_ADDR. The loader then writes the reset
//   vector at $FFFC/$FFFD so that it points at BASE_ADDR, and releases the CPU.
//
//   Optional feature: define FW_LOADER_CHECKSUM_EN to enable it. After the
//   payload, one trailer byte is accepted. The 8-bit sum of the payload plus
//   the trailer must be zero, otherwise the load aborts.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset
//   start        single-cycle load request
//   len          payload byte count, sampled on an accepted start
//   bus          stream input and memory write port (slave modport)
//   cpu_reset_n  CPU reset, active-low; high only after a successful load
//   done         load complete and CPU released (level)
//   error        load aborted (level)
//   byte_count   payload bytes accepted so far in the current load
// ----------------------------------------------------------------------------
module fw_boot_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0600,
  parameter int                    MAX_LEN    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  fw_boot_loader_if.slave       bus,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] byte_count
);

  localparam logic [ADDR_WIDTH-1:0] VEC_LO_ADDR = ADDR_WIDTH'(16'hFFFC);
  localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = ADDR_WIDTH'(16'hFFFD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
`ifdef FW_LOADER_CHECKSUM_EN
    ST_CKSUM  = 3'd2,
`endif
    ST_VEC_LO = 3'd3,
    ST_VEC_HI = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] len_q;
  logic                  run_q;
  logic                  handshake;
  logic                  last_byte;
  logic                  start_take;
  logic                  start_legal;
  logic [ADDR_WIDTH:0]   end_addr;

`ifdef FW_LOADER_CHECKSUM_EN
  logic [REG_WIDTH-1:0]  sum_q;
  logic [REG_WIDTH-1:0]  sum_final;
  assign sum_final   = sum_q + bus.in_data;
  assign bus.in_ready = (state == ST_STREAM) || (state == ST_CKSUM);
`else
  assign bus.in_ready = (state == ST_STREAM);
`endif

  assign handshake  = bus.in_valid && bus.in_ready;
  assign last_byte  = (byte_count == len_q - ADDR_WIDTH'(1));
  assign start_take = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERROR));

  // The last payload address is computed one bit wider than ADDR_WIDTH. A
  // huge len therefore cannot wrap past the vector bytes and look legal.
  assign end_addr    = {1'b0, BASE_ADDR} + {1'b0, len} - (ADDR_WIDTH+1)'(1);
  assign start_legal = (len != '0) && (32'(len) <= $unsigned(MAX_LEN)) &&
                       (end_addr < {1'b0, VEC_LO_ADDR});

  // done and cpu_reset_n rise one cycle after RUN is entered. That cycle
  // follows the $FFFD write. Both fall on the same edge that leaves RUN.
  assign done        = run_q;
  assign cpu_reset_n = run_q;
  assign error       = (state == ST_ERROR);

  // NOTE: next_state gets its default before the case. A path that forgets
  // to assign it then keeps the current state instead of inferring a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start_take) next_state = start_legal ? ST_STREAM : ST_ERROR;
      end
      ST_STREAM: begin
`ifdef FW_LOADER_CHECKSUM_EN
        if (handshake && last_byte) next_state = ST_CKSUM;
`else
        if (handshake && last_byte) next_state = ST_VEC_LO;
`endif
      end
`ifdef FW_LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        if (handshake) next_state = (sum_final == '0) ? ST_VEC_LO : ST_ERROR;
      end
`endif
      ST_VEC_LO: next_state = ST_VEC_HI;
      ST_VEC_HI: next_state = ST_RUN;
      default:   next_state = ST_IDLE;
    endcase
  end

  // NOTE: every register here is assigned with <=. All reads then see
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      byte_count   <= '0;
      run_q        <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
`ifdef FW_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state      <= next_state;
      run_q      <= (state == ST_RUN) && (next_state == ST_RUN);
      bus.mem_we <= 1'b0;

      if (start_take && start_legal) begin
        len_q      <= len;
        byte_count <= '0;
`ifdef FW_LOADER_CHECKSUM_EN
        sum_q      <= '0;
`endif
      end

      unique case (state)
        ST_STREAM: begin
          if (handshake) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= BASE_ADDR + byte_count;
            bus.mem_din  <= bus.in_data;
            byte_count   <= byte_count + ADDR_WIDTH'(1);
`ifdef FW_LOADER_CHECKSUM_EN
            sum_q        <= sum_final;
`endif
          end
        end
        ST_VEC_LO: begin
          bus.mem_we   <= 1'b1;
          bus.mem_addr <= VEC_LO_ADDR;
          bus.mem_din  <= BASE_ADDR[REG_WIDTH-1:0];
        end
        ST_VEC_HI: begin
          bus.mem_we   <= 1'b1;
          bus.mem_addr <= VEC_HI_ADDR;
          bus.mem_din  <= BASE_ADDR[ADDR_WIDTH-1 -: REG_WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_fw_boot_loader
//   Self-checking bench for fw_boot_loader. Expected memory writes are queued
//   as each byte is driven. A negedge monitor pops them and compares them
//   with every mem_we pulse. Level outputs and timing are checked inline.
// ----------------------------------------------------------------------------
module tb_fw_boot_loader;

  localparam logic [15:0] BASE = 16'h0600;
`ifdef FW_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        cpu_reset_n;
  logic        done;
  logic        error;
  logic [15:0] byte_count;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          wr_cyc[$];
  logic [7:0]  pay[$];
  logic [15:0] bad_len [3];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          spurious = 0;
  int          hs;

  fw_boot_loader_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

  fw_boot_loader #(
    .ADDR_WIDTH(16),
    .REG_WIDTH (8),
    .BASE_ADDR (16'h0600),
    .MAX_LEN   (4096)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .bus        (bus),
    .cpu_reset_n(cpu_reset_n),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) spurious++;
      else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, mon_e.addr);
        check("wr_data", bus.mem_din, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // When the checksum build is active, append the byte that makes the sum zero.
  task automatic add_trailer();
    logic [7:0] s;
    s = 8'h00;
    foreach (pay[i]) s = s + pay[i];
    if (CK_EN) pay.push_back(8'h00 - s);
  endtask

  task automatic push_vectors();
    exp_q.push_back('{16'hFFFC, 8'h00});
    exp_q.push_back('{16'hFFFD, 8'h06});
  endtask

  // Sends every byte in pay. The first n_payload bytes are expected in memory.
  // stall inserts an idle cycle before each byte. poke also pulses an illegal
  // start during that idle cycle.
  task automatic send_bytes(input int n_payload, input bit stall, input bit poke,
                            output int hs_cyc);
    bit rdy;
    hs_cyc = 0;
    for (int i = 0; i < pay.size(); i++) begin
      if (stall) begin
        bus.in_valid = 1'b0;
        if (poke) begin
          start = 1'b1;
          len   = 16'd0;
        end
        step();
        start = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = pay[i];
      if (i < n_payload) exp_q.push_back('{BASE + 16'(i), pay[i]});
      rdy = 1'b0;
      for (int t = 0; t < 20 && !rdy; t++) begin
        @(negedge clk);
        rdy = bus.in_ready;
        @(posedge clk);
        #1;
      end
      check("hs_ready", rdy, 1);
      hs_cyc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    len          = 16'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bad_len      = '{16'd0, 16'd4097, 16'hF9FD};

    // Reset values.
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_byte_count", byte_count, 0);
    reset = 1'b0;
    step();

    // Load 3 bytes with in_valid held high; check the vector and done timing.
    wr_cyc.delete();
    pay = '{8'hA9, 8'h05, 8'h00};
    add_trailer();
    pulse_start(16'd3);
    send_bytes(3, 1'b0, 1'b0, hs);
    push_vectors();
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      check("t1_done", done, (d == 3));
    end
    check("t1_cpu_reset_n", cpu_reset_n, 1);
    check("t1_n_writes", wr_cyc.size(), 5);
    if (wr_cyc.size() == 5) begin
      check("t1_write_span", wr_cyc[4] - wr_cyc[0], CK_EN ? 5 : 4);
      check("t1_fffd_cycle", wr_cyc[4], hs + 2);
    end
    check("t1_sb_empty", exp_q.size(), 0);

    // Reload from RUN, stalled stream, ignored start pulses during STREAM.
    step();
    pulse_start(16'd4);
    @(negedge clk);
    check("t2_done_fall", done, 0);
    check("t2_cpu_reset_fall", cpu_reset_n, 0);
    check("t2_streaming", bus.in_ready, 1);
    check("t2_count_clr", byte_count, 0);
    wr_cyc.delete();
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    add_trailer();
    send_bytes(4, 1'b1, 1'b1, hs);
    check("t2_byte_count", byte_count, 4);
    push_vectors();
    repeat (4) @(negedge clk);
    check("t2_done", done, 1);
    check("t2_error", error, 0);
    check("t2_n_writes", wr_cyc.size(), 6);
    check("t2_sb_empty", exp_q.size(), 0);

    // Illegal lengths: the first from RUN, the rest from IDLE.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) do_reset();
      wr_cyc.delete();
      pulse_start(bad_len[i]);
      @(negedge clk);
      check("t3_error", error, 1);
      check("t3_cpu_reset_n", cpu_reset_n, 0);
      check("t3_done", done, 0);
      check("t3_in_ready", bus.in_ready, 0);
      repeat (3) @(negedge clk);
      check("t3_no_writes", wr_cyc.size(), 0);
    end

    // Largest legal length is accepted.
    do_reset();
    pulse_start(16'd4096);
    @(negedge clk);
    check("t3_max_len_err", error, 0);
    check("t3_max_len_stream", bus.in_ready, 1);

    // Reset mid-load after 2 of 5 bytes, then a fresh complete load.
    do_reset();
    wr_cyc.delete();
    pulse_start(16'd5);
    pay = '{8'h01, 8'h02};
    send_bytes(2, 1'b0, 1'b0, hs);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("t4_rst_in_ready", bus.in_ready, 0);
    check("t4_rst_cpu_reset_n", cpu_reset_n, 0);
    check("t4_rst_byte_count", byte_count, 0);
    check("t4_rst_error", error, 0);
    reset = 1'b0;
    repeat (3) step();
    check("t4_partial_writes", wr_cyc.size(), 2);
    check("t4_partial_sb", exp_q.size(), 0);
    wr_cyc.delete();
    pulse_start(16'd5);
    pay = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    add_trailer();
    send_bytes(5, 1'b0, 1'b0, hs);
    push_vectors();
    repeat (4) @(negedge clk);
    check("t4_done", done, 1);
    check("t4_cpu_reset_n", cpu_reset_n, 1);
    check("t4_n_writes", wr_cyc.size(), 7);
    check("t4_sb_empty", exp_q.size(), 0);

`ifdef FW_LOADER_CHECKSUM_EN
    // Good trailer: the load completes and the trailer is not written.
    step();
    wr_cyc.delete();
    pulse_start(16'd2);
    pay = '{8'h10, 8'h20, 8'hD0};
    send_bytes(2, 1'b0, 1'b0, hs);
    push_vectors();
    repeat (4) @(negedge clk);
    check("t5_done", done, 1);
    check("t5_n_writes", wr_cyc.size(), 4);
    // Bad trailer: ERROR one cycle after it, and no vector writes.
    step();
    wr_cyc.delete();
    pulse_start(16'd2);
    pay = '{8'h10, 8'h20, 8'hD1};
    send_bytes(2, 1'b0, 1'b0, hs);
    @(negedge clk);
    check("t5_bad_error", error, 1);
    check("t5_bad_cpu_reset_n", cpu_reset_n, 0);
    repeat (3) @(negedge clk);
    check("t5_bad_n_writes", wr_cyc.size(), 2);
    check("t5_bad_sb_empty", exp_q.size(), 0);
`endif

    check("spurious_we", spurious, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fw_boot_loader.md
# fw_boot_loader

Synchronous firmware loader that sits upstream of the `mem` block and `cpu_top`. While the CPU is held in reset, it accepts a byte stream over a valid/ready handshake and writes the stream into memory starting at `BASE_ADDR`. It then writes the 6502 reset vector at $FFFC/$FFFD to point at `BASE_ADDR` and releases the CPU. In hardware it replaces the bench's memory-override preload path.

## Interface
- `ADDR_WIDTH`, 16, memory address width.
- `REG_WIDTH`, 8, data byte width.
- `BASE_ADDR`, 16'h0600, first load address and reset-vector target.
- `MAX_LEN`, 4096, largest legal payload length in bytes.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle load request.
- `len`  in  16  payload byte count, sampled when `start` is accepted.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  16  memory write address.
- `mem_din`  out  8  memory write data.
- `cpu_reset_n`  out  1  CPU reset, active-low; drives `cpu_top.reset_n`.
- `done`  out  1  load completed and CPU released; level signal.
- `error`  out  1  load aborted; level signal.
- `byte_count`  out  16  payload bytes accepted so far in the current load.

## Operation
- States: IDLE, STREAM, CKSUM (macro only), VEC_LO, VEC_HI, RUN, ERROR.
- IDLE: waits for `start`.
  - `start` with `len`==0, `len`>`MAX_LEN`, or `BASE_ADDR`+`len`-1 ≥ 16'hFFFC → ERROR.
  - `start` with a legal `len` → STREAM; `len` is latched and `byte_count` is cleared.
- STREAM: `in_ready`=1.
  - Each handshake (`in_valid`&&`in_ready`) writes `in_data` to `BASE_ADDR`+`byte_count`, then increments `byte_count`.
  - The handshake that accepts the last byte (`byte_count`==`len`-1) moves the FSM to CKSUM, or to VEC_LO when the macro is off.
  - `in_valid` low stalls the FSM indefinitely. There is no timeout.
- VEC_LO: one write of `BASE_ADDR[7:0]` to 16'hFFFC, then → VEC_HI.
- VEC_HI: one write of `BASE_ADDR[15:8]` to 16'hFFFD, then → RUN.
- RUN: `cpu_reset_n`=1 and `done`=1.
- ERROR: `error`=1 and `cpu_reset_n`=0.
- From RUN or ERROR, `start` re-runs the IDLE legality check in the same cycle: STREAM or ERROR. This clears `done` and `error` and drops `cpu_reset_n` to 0.
- `start` in STREAM, CKSUM, VEC_LO or VEC_HI is ignored.
- `in_ready` is 0 in every state except STREAM and CKSUM.
- Address arithmetic is 16-bit unsigned. No wrap is possible, because the legality check rejects overlap with the vector bytes.

## Timing
- Reset values:
  - FSM = IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `cpu_reset_n`=0, `done`=0, `error`=0, `byte_count`=0.
- Memory outputs are registered. A handshake in cycle N produces `mem_we`=1 with the matching address and data in cycle N+1. `mem_we` is a single-cycle pulse per byte.
- Back-to-back handshakes give one write per cycle, for a throughput of 1 byte/clk.
- After the last payload handshake in cycle N (macro off):
  - N+1: last payload write, FSM in VEC_LO.
  - N+2: $FFFC write.
  - N+3: $FFFD write.
  - N+4: `done`=1 and `cpu_reset_n`=1.
- With the macro on, each of these steps moves one handshake later, after the checksum byte is accepted.
- Entering ERROR from a start check: `error`=1 one cycle after `start`.
- `reset` asserted mid-load returns the block to IDLE on the next edge and drops `cpu_reset_n`. Bytes already written stay in memory, and no vector is written.
- `reset` has priority over `start`.

## Configuration
- `FW_LOADER_CHECKSUM_EN` defined:
  - After the payload, CKSUM accepts one extra byte, which is not written to memory.
  - If the 8-bit sum of all `len`+1 bytes is not 0 → ERROR one cycle later, with no vector writes and `cpu_reset_n` held at 0.
  - If the sum is 0 → VEC_LO.
- `FW_LOADER_CHECKSUM_EN` undefined:
  - CKSUM does not exist; STREAM goes directly to VEC_LO.
  - No adder is synthesized.

## Test plan
- Load 3 bytes: `len`=3, stream A9,05,00 with `in_valid` held high (macro off).
  - Writes: $0600=A9, $0601=05, $0602=00, $FFFC=00, $FFFD=06, on consecutive cycles.
  - `done` rises 4 cycles after the last handshake, together with `cpu_reset_n`=1.
- Stall: toggle `in_valid` 1/0 while streaming 4 bytes.
  - Exactly 4 `mem_we` pulses at $0600–$0603.
  - `byte_count` ends at 4.
- Illegal start, one run per value: `len`=0, `len`=4097, and `len`=16'hF9FD (ends at $FFFC).
  - Each gives `error`=1 on the cycle after `start`, with no `mem_we` and `cpu_reset_n`=0.
- Checksum (macro on): `len`=2, stream 10,20,D0.
  - Gives `done`=1, and no write to $0602.
  - Repeat with trailer D1: gives `error`=1 and no writes to $FFFC/$FFFD.
- Reset mid-load: assert `reset` after 2 of 5 bytes.
  - Block returns to IDLE with `cpu_reset_n`=0.
  - A fresh `start` with `len`=5 completes normally.
- Reload from RUN: pulse `start` while in RUN.
  - `cpu_reset_n` falls, `done` falls, and the block enters STREAM on the next cycle.
  - `start` pulses during STREAM are ignored.
